// File: rtl/ifm_pf_pkg.sv
// rtl/ifm_pf_pkg.sv - shared types and constants for the ifm_pf prefetching fetch stage
package ifm_pf_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  // Counters must hold the full-queue value, hence one bit above the index width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifm_pf_if.sv
// rtl/ifm_pf_if.sv - instruction bus and decode handshake bundle for ifm_pf
// IFM_PF_BUS_ERR_EN adds wb_err_i and fetch_err_o.
interface ifm_pf_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stall_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        output_ready_i;
  logic        output_valid_o;
`ifdef IFM_PF_BUS_ERR_EN
  logic        wb_err_i;
  logic        fetch_err_o;
`endif

  modport master (
`ifdef IFM_PF_BUS_ERR_EN
    input  wb_err_i,
    output fetch_err_o,
`endif
    output wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i,
    output instr_o, pc_o, output_valid_o,
    input  output_ready_i
  );

  modport slave (
`ifdef IFM_PF_BUS_ERR_EN
    output wb_err_i,
    input  fetch_err_o,
`endif
    input  wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i,
    input  instr_o, pc_o, output_valid_o,
    output output_ready_i
  );
endinterface

// File: rtl/ifm_pf_fifo.sv
// rtl/ifm_pf_fifo.sv - prefetch queue of {pc, instr, err} entries; flush beats push and pop
module ifm_pf_fifo
  import ifm_pf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  entry_t                      data_i,
  output entry_t                      head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        empty_o,
  output logic                        full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ifm_pf.sv
// rtl/ifm_pf.sv - prefetching instruction fetch with pipelined Wishbone reads
// IFM_PF_BUS_ERR_EN turns bus errors into flagged NOP entries that halt issue until a branch.
module ifm_pf
  import ifm_pf_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic        drq_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  ifm_pf_if.master    bus
);
  localparam int              CW      = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);

  entry_t        head, push_e;
  logic [CW-1:0] count, out_q, out_d, disc_q, disc_d;
  logic [31:0]   pc_q, pc_d, ack_pc_q, ack_pc_d, tgt;
  logic          hold_q, hold_d, halt_q, err_in;
  logic          empty, full, issue_ok, accept, term, push, pop;

`ifdef IFM_PF_BUS_ERR_EN
  assign err_in = bus.wb_err_i;
  assign bus.fetch_err_o = ~empty & head.err;
  always_ff @(posedge clk_i) begin
    if (rst_i || branch_i) halt_q <= 1'b0;
    else if (push && err_in) halt_q <= 1'b1;
  end
`else
  assign err_in = 1'b0;
  assign halt_q = 1'b0;
`endif

  assign tgt      = {branch_target_i[31:2], 2'b00};
  assign term     = (bus.wb_ack_i | err_in) & (out_q != '0);
  // Outstanding credits reserve queue space, so every landing ack has a slot.
  assign issue_ok = ~irq_i & ~drq_i & ~halt_q & ~full & (out_q < MAX_C)
                  & (({1'b0, out_q} + {1'b0, count}) < DEPTH_C);
  assign bus.wb_stb_o = ~rst_i & ~branch_i & (hold_q | issue_ok);
  assign accept   = bus.wb_stb_o & ~bus.wb_stall_i;
  assign push     = term & (disc_q == '0) & ~branch_i;
  assign pop      = bus.output_valid_o & bus.output_ready_i & ~branch_i;
  assign push_e   = '{pc: ack_pc_q, instr: (err_in ? NOP_INSTR : bus.wb_dat_i), err: err_in};

  assign bus.wb_adr_o       = pc_q;
  assign bus.wb_we_o        = 1'b0;
  assign bus.wb_sel_o       = 4'hF;
  assign bus.wb_cyc_o       = bus.wb_stb_o | (out_q != '0);
  assign bus.output_valid_o = ~empty;
  assign bus.instr_o        = empty ? 32'h0 : (head.err ? NOP_INSTR : head.instr);
  assign bus.pc_o           = empty ? 32'h0 : head.pc;

  always_comb begin
    out_d    = out_q + CW'(accept) - CW'(term);
    pc_d     = accept ? pc_q + 32'd4 : pc_q;
    ack_pc_d = push ? ack_pc_q + 32'd4 : ack_pc_q;
    disc_d   = (term && disc_q != '0) ? disc_q - 1'b1 : disc_q;
    hold_d   = bus.wb_stb_o & bus.wb_stall_i;
    if (branch_i) begin
      pc_d     = tgt;
      ack_pc_d = tgt;
      disc_d   = out_q - CW'(term);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= BOOT_ADDR;
      ack_pc_q <= BOOT_ADDR;
      out_q    <= '0;
      disc_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ack_pc_q <= ack_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      hold_q   <= hold_d;
    end
  end

  ifm_pf_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (branch_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_e),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );
endmodule

// File: tb/tb_ifm_pf.sv
// tb/tb_ifm_pf.sv - self-checking bench for ifm_pf with a pipelined slave and expected decode stream
module tb_ifm_pf;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAX   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct { logic [31:0] adr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit err; } ent_t;

  logic        clk = 1'b0;
  logic        rst, irq, drq, br;
  logic [31:0] tgt;
  ifm_pf_if    bus();

  ifm_pf #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .irq_i           (irq),
    .drq_i           (drq),
    .branch_i        (br),
    .branch_target_i (tgt),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls for the next cycle.
  bit          c_rst, c_irq, c_drq, c_br, c_stall, c_ready, c_ack_en, c_spur, c_err_on;
  logic [31:0] c_tgt, c_err_adr;

  // Reference model: requests the slave holds, entries decode should see, next fetch PC.
  req_t        slv_q[$];
  ent_t        exp_q[$];
  logic [31:0] m_pc;
  bit          m_held, m_halt;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit   ack_t, err_t, e_stb, acc, pop;
    req_t r;
    @(negedge clk);
    rst = c_rst; irq = c_irq; drq = c_drq; br = c_br; tgt = c_tgt;
    bus.wb_stall_i     = c_stall;
    bus.output_ready_i = c_ready;
    ack_t = c_ack_en && (slv_q.size() != 0);
    err_t = ack_t && c_err_on && (slv_q[0].adr == c_err_adr);
    bus.wb_ack_i = (ack_t && !err_t) || (c_spur && slv_q.size() == 0);
`ifdef IFM_PF_BUS_ERR_EN
    bus.wb_err_i = err_t;
`endif
    bus.wb_dat_i = ack_t ? hash(slv_q[0].adr) : 32'hDEAD_BEEF;
    #1;
    e_stb = !c_rst && !c_br && (m_held || (!c_irq && !c_drq && !m_halt &&
            slv_q.size() < MAX && slv_q.size() + exp_q.size() < DEPTH));
    chk("stb", bus.wb_stb_o, e_stb);
    if (e_stb) chk("adr", bus.wb_adr_o, m_pc);
    chk("cyc", bus.wb_cyc_o, e_stb || slv_q.size() != 0);
    chk("valid", bus.output_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("pc", bus.pc_o, exp_q[0].pc);
      chk("instr", bus.instr_o, exp_q[0].instr);
`ifdef IFM_PF_BUS_ERR_EN
      chk("fetch_err", bus.fetch_err_o, exp_q[0].err);
`endif
    end
    if (c_rst) begin
      chk("rst_adr", bus.wb_adr_o, BOOT);
      chk("rst_instr", bus.instr_o, 32'h0);
      chk("rst_pc", bus.pc_o, 32'h0);
    end
    acc = e_stb && !c_stall;
    pop = (exp_q.size() != 0) && c_ready;
    @(posedge clk);
    if (c_rst) begin
      slv_q.delete(); exp_q.delete();
      m_pc = BOOT; m_held = 0; m_halt = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (ack_t) begin
        r = slv_q.pop_front();
        if (!r.stale) begin
          exp_q.push_back('{r.adr, err_t ? NOP : hash(r.adr), err_t});
          if (err_t) m_halt = 1;
        end
      end
      if (acc) begin
        slv_q.push_back('{m_pc, 1'b0});
        m_pc += 32'd4;
      end
      m_held = e_stb && c_stall;
      if (c_br) begin
        exp_q.delete();
        foreach (slv_q[i]) slv_q[i].stale = 1;
        m_pc = {c_tgt[31:2], 2'b00};
        m_halt = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; irq = 0; drq = 0; br = 0; tgt = 0;
    bus.wb_dat_i = 0; bus.wb_ack_i = 0; bus.wb_stall_i = 0; bus.output_ready_i = 0;
`ifdef IFM_PF_BUS_ERR_EN
    bus.wb_err_i = 0;
`endif
    c_rst = 1; c_irq = 0; c_drq = 0; c_br = 0; c_stall = 0; c_ready = 1;
    c_ack_en = 0; c_spur = 1; c_err_on = 0; c_tgt = 0; c_err_adr = 0;
    m_pc = BOOT; m_held = 0; m_halt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("we", bus.wb_we_o, 1'b0);
    chk("sel", bus.wb_sel_o, 4'hF);

    // Reset with stray acks, then one stray ack while nothing is outstanding.
    run(3);
    c_rst = 0;
    run(1);
    c_spur = 0;

    // Streaming: ack every cycle, decode always ready.
    c_ack_en = 1;
    run(14);

    // Decode stalls: queue fills, issue stops, then drains and fetch resumes.
    c_ready = 0;
    run(10);
    c_ready = 1;
    run(10);

    // Slave stall holds the presented request.
    c_stall = 1;
    run(3);
    c_stall = 0;
    run(6);

    // Branch to an unaligned target with two requests in flight.
    c_ack_en = 0;
    run(3);
    c_br = 1; c_tgt = 32'h0000_0103;
    run(1);
    c_br = 0; c_ack_en = 1;
    run(12);

    // Debug request: nothing new issued, in-flight and queued entries still drain.
    c_ready = 0; c_ack_en = 0;
    run(3);
    c_ack_en = 1;
    run(1);
    c_drq = 1;
    run(2);
    c_ready = 1;
    run(5);
    c_drq = 0;
    run(8);

    // Branch while an earlier branch's discards are still pending.
    c_ack_en = 0;
    run(2);
    c_br = 1; c_tgt = 32'h0000_2000;
    run(1);
    c_tgt = 32'h0000_3000;
    run(1);
    c_br = 0; c_ack_en = 1;
    run(10);

`ifdef IFM_PF_BUS_ERR_EN
    c_br = 1; c_tgt = 32'h0;
    run(1);
    c_br = 0; c_err_on = 1; c_err_adr = 32'h4; c_ready = 0;
    run(8);
    c_ready = 1;
    run(6);
    c_err_on = 0; c_br = 1; c_tgt = 32'h40;
    run(1);
    c_br = 0;
    run(10);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      c_stall  = ($urandom_range(0, 3) == 0);
      c_ack_en = ($urandom_range(0, 3) != 0);
      c_ready  = ($urandom_range(0, 2) != 0);
      c_irq    = ($urandom_range(0, 15) == 0);
      c_drq    = ($urandom_range(0, 15) == 0);
      c_br     = ($urandom_range(0, 23) == 0);
      c_spur   = ($urandom_range(0, 7) == 0);
      c_tgt    = $urandom;
      step();
    end
    c_irq = 0; c_drq = 0; c_br = 0; c_stall = 0; c_spur = 0; c_ack_en = 1; c_ready = 1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ifm_pf.md
Name: ifm_pf

Overview:
Parametrised prefetching instruction fetch module, the next generation of the single-request fetch stage.
- Keeps up to MAX_OUTSTANDING pipelined Wishbone reads in flight.
- Buffers returned instructions with their PC in a FIFO_DEPTH-entry prefetch queue.
- Presents them to decode through a valid/ready handshake.
- Sits between the instruction bus and decode; branches and irq/drq control the fetch stream.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
FIFO_DEPTH, 4, prefetch queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum unacknowledged bus requests (1..FIFO_DEPTH)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
irq_i  in  1  interrupt pending; inhibits new request issue while high
drq_i  in  1  debug request; inhibits new request issue while high
branch_i  in  1  redirect fetch stream (single-cycle pulse)
branch_target_i  in  32  redirect address (bits [1:0] ignored, forced 0)
wb_adr_o  out  32  request address
wb_dat_i  in  32  read data
wb_we_o  out  1  constant 0
wb_sel_o  out  4  constant 4'hF
wb_stb_o  out  1  request strobe
wb_ack_i  in  1  request completion
wb_cyc_o  out  1  bus cycle active
wb_stall_i  in  1  slave cannot accept request
instr_o  out  32  instruction at queue head
pc_o  out  32  address of instr_o
output_ready_i  in  1  decode accepts head
output_valid_o  out  1  head valid

Behaviour:
- Reset: wb_stb_o=0, wb_cyc_o=0, wb_adr_o=BOOT_ADDR, output_valid_o=0, instr_o=0, pc_o=0. Fetch PC=BOOT_ADDR, queue empty, outstanding=0, discard=0. An ack arriving during or after reset with outstanding==0 is ignored.
- Issue rule: a request is presented (wb_stb_o=1, wb_adr_o=fetch PC) when all of the following hold:
  - not irq_i, not drq_i, not branch_i;
  - outstanding < MAX_OUTSTANDING;
  - outstanding + queue count < FIFO_DEPTH.
- A request is accepted on a cycle with wb_stb_o & !wb_stall_i. Then fetch PC += 4 (wraps mod 2^32) and outstanding increments.
- While wb_stall_i is high, wb_stb_o and wb_adr_o are held stable. Issue inhibitors never drop an already-presented stalled strobe, except branch_i and reset.
- First request: stb asserted the cycle after rst_i deasserts.
- wb_cyc_o = wb_stb_o | (outstanding != 0).
- Ack: outstanding decrements.
  - If discard != 0: discard decrements and the data is dropped.
  - Otherwise {PC of oldest request, wb_dat_i} is pushed into the queue.
- Simultaneous accept and ack: outstanding is unchanged.
- Latency: an ack in cycle N gives output_valid_o=1 in cycle N+1 if the queue was empty.
- Output: head entry drives instr_o/pc_o; output_valid_o = queue not empty. Pop on valid & ready. Outputs are stable while valid & !ready.
- Branch (cycle B):
  - queue flushed; fetch PC = {branch_target_i[31:2],2'b00};
  - discard = outstanding minus any ack taken in cycle B;
  - a stalled strobe is withdrawn; output_valid_o=0 in B+1;
  - the new request is presented in B+1 if the issue rule permits.
  - Branch wins over a pop or push in the same cycle.
- Boundaries:
  - full queue: no issue, acks still land because credits reserve space;
  - empty queue and ready: no pop;
  - branch while discard != 0: discard is recomputed from the current outstanding;
  - irq/drq high: in-flight acks and queued entries still drain to decode.

Optional Feature:
IFM_PF_BUS_ERR_EN
- Defined:
  - adds input wb_err_i (1) and output fetch_err_o (1);
  - err terminates a request like ack and pushes an entry with the error flag set and instr=32'h0000_0013 (NOP);
  - fetch_err_o is that flag at the head;
  - after an err, issue halts until branch_i;
  - err during discard is dropped.
- Undefined: no ports are added and error handling is absent.

Decomposition:
- Package ifm_pf_pkg holds:
  - entry struct {pc[31:0], instr[31:0], err};
  - NOP_INSTR constant 32'h0000_0013;
  - the width function for counters, $clog2(FIFO_DEPTH)+1.
- Sub-module ifm_pf_fifo: synchronous FIFO of entries with push, pop, flush, count, empty/full. Flush has priority over push and pop.

Test Plan:
1. Reset release, slave acks every cycle without stall -> adr 0x0,0x4,0x8... back-to-back, with at most 2 outstanding. With ready=1, pc_o sequence is 0x0,0x4,0x8 and the instr values match.
2. output_ready_i=0, FIFO_DEPTH=4 -> exactly 4 requests accepted, then stb=0 while cyc drops. Raise ready -> 4 ordered outputs, then fetch resumes at 0x10.
3. wb_stall_i=1 for 3 cycles at adr 0x8 -> adr and stb held at 0x8 for those 3 cycles, with no PC advance.
4. Branch to 0x103 with 2 outstanding -> the next 2 acks are dropped, valid=0 in the following cycle, and the next output pc_o=0x100.
5. drq_i=1 with 1 outstanding and 2 queued -> no new stb. All 3 entries are delivered; after drq_i falls, fetch continues from the next sequential PC.
6. Define IFM_PF_BUS_ERR_EN and err on adr 0x4 -> output pc=0x4, instr=0x13, fetch_err_o=1, then no issue until a branch to 0x40 resumes fetching.
